// File: rtl/pipe_hazard_ctrl_pkg.sv
// +-----------------------------------------------------------------+
// | pipe_pkg: shared types for the pipeline stall/flush controller  |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

package pipe_pkg;

   typedef enum logic [1:0] {
      M_IDLE = 2'd0,
      M_ADDR = 2'd1,
      M_DATA = 2'd2
   } mem_state_t;

   typedef enum logic [1:0] {
      D_IDLE = 2'd0,
      D_BUSY = 2'd1,
      D_DONE = 2'd2
   } div_state_t;

   localparam logic [5:0] REG_ZERO = 6'd0;

   typedef struct packed {
      logic pc_stall;
      logic if_id_stall;
      logic id_ex_stall;
      logic ex_mem_stall;
      logic if_id_flush;
      logic id_ex_flush;
      logic ex_mem_flush;
      logic mem_wb_flush;
   } hazard_ctl_t;

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_div_sched.sv
// +-----------------------------------------------------------------+
// | div_sched: multi-cycle divide scheduler and busy counter        |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module div_sched
   import pipe_pkg::*;
#(
   parameter int DIV_CYCLES = 33
) (
   input  logic clk,
   input  logic resetn,
   input  logic ex_div,
   input  logic adv,
   input  logic kill,
   output logic div_stall,
   output logic div_busy,
   output logic div_done
);

   // The first (idle) cycle counts as one stall cycle, hence the minus one.
   localparam logic [5:0] CNT_LOAD = 6'(DIV_CYCLES - 1);

   div_state_t state;
   div_state_t state_nxt;
   logic [5:0] cnt;
   logic [5:0] cnt_nxt;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      div_stall = 1'b0;
      div_busy  = 1'b0;
      div_done  = 1'b0;
      case (state)
         D_IDLE: begin
            if (ex_div) begin
               div_stall = 1'b1;
               cnt_nxt   = CNT_LOAD;
               state_nxt = D_BUSY;
            end
         end
         D_BUSY: begin
            div_busy = 1'b1;
            if (cnt != 6'd0) begin
               div_stall = 1'b1;
               cnt_nxt   = cnt - 6'd1;
            end else begin
               div_done  = 1'b1;
               state_nxt = adv ? D_IDLE : D_DONE;
            end
         end
         D_DONE: begin
            div_done = 1'b1;
            if (adv) state_nxt = D_IDLE;
         end
         default: state_nxt = D_IDLE;
      endcase
      if (kill) state_nxt = D_IDLE;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= D_IDLE;
         cnt   <= 6'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// +-----------------------------------------------------------------+
// | pipe_hazard_ctrl: 5-stage pipeline stall/flush controller       |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int DIV_CYCLES = 33
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [5:0] id_rs,
   input  logic [5:0] id_rt,
   input  logic       id_rs_ren,
   input  logic       id_rt_ren,
   input  logic       ex_load,
   input  logic       ex_regwen,
   input  logic [5:0] ex_wreg,
   input  logic       ex_div,
   input  logic       mem_data_en,
   input  logic       mem_exc,
   input  logic       data_addr_ok,
   input  logic       data_data_ok,
   input  logic       if_wait,
   output logic       data_req,
   output logic       div_busy,
   output logic       div_done,
   output logic       exc_take,
   output logic       pc_stall,
   output logic       if_id_stall,
   output logic       id_ex_stall,
   output logic       ex_mem_stall,
   output logic       if_id_flush,
   output logic       id_ex_flush,
   output logic       ex_mem_flush,
   output logic       mem_wb_flush
);

   mem_state_t  mstate;
   mem_state_t  mstate_nxt;
   logic        exc_pend;
   logic        req;
   logic        complete;
   logic        mem_wait;
   logic        lu;
   logic        take;
   logic        div_stall_int;
   logic        div_busy_int;
   logic        div_done_int;
   hazard_ctl_t ctl;

   always_comb begin
      req        = 1'b0;
      mstate_nxt = mstate;
      case (mstate)
         M_IDLE: begin
            req = mem_data_en & ~mem_exc;
            if (req) mstate_nxt = data_addr_ok ? M_DATA : M_ADDR;
         end
         M_ADDR: begin
            req = 1'b1;
            if (data_addr_ok) mstate_nxt = M_DATA;
         end
         M_DATA: begin
            if (data_data_ok) mstate_nxt = M_IDLE;
         end
         default: mstate_nxt = M_IDLE;
      endcase
   end

   assign complete = (mstate == M_DATA) & data_data_ok;
   assign mem_wait = ((mstate == M_IDLE) & req) | (mstate == M_ADDR)
                   | ((mstate == M_DATA) & ~data_data_ok);

   assign lu = ex_load & ex_regwen & (ex_wreg != REG_ZERO)
             & ((id_rs_ren & (id_rs == ex_wreg)) | (id_rt_ren & (id_rt == ex_wreg)));

   always_comb begin
      ctl  = '0;
      take = 1'b0;
      if (mem_exc & (mstate == M_IDLE)) begin
         take             = 1'b1;
         ctl.if_id_flush  = 1'b1;
         ctl.id_ex_flush  = 1'b1;
         ctl.ex_mem_flush = 1'b1;
         ctl.mem_wb_flush = 1'b1;
      end else if (complete & (exc_pend | mem_exc)) begin
         // The finishing access retires into MEM/WB; everything younger dies.
         take             = 1'b1;
         ctl.if_id_flush  = 1'b1;
         ctl.id_ex_flush  = 1'b1;
         ctl.ex_mem_flush = 1'b1;
      end else if (mem_wait) begin
         ctl.pc_stall     = 1'b1;
         ctl.if_id_stall  = 1'b1;
         ctl.id_ex_stall  = 1'b1;
         ctl.ex_mem_stall = 1'b1;
         ctl.mem_wb_flush = 1'b1;
      end else if (div_stall_int) begin
         ctl.pc_stall     = 1'b1;
         ctl.if_id_stall  = 1'b1;
         ctl.id_ex_stall  = 1'b1;
         ctl.ex_mem_flush = 1'b1;
      end else if (lu) begin
         ctl.pc_stall     = 1'b1;
         ctl.if_id_stall  = 1'b1;
         ctl.id_ex_flush  = 1'b1;
      end else if (if_wait) begin
         ctl.pc_stall     = 1'b1;
         ctl.if_id_flush  = 1'b1;
      end
   end

   assign data_req     = resetn & req;
   assign exc_take     = resetn & take;
   assign div_busy     = resetn & div_busy_int;
   assign div_done     = resetn & div_done_int;
   assign pc_stall     = resetn & ctl.pc_stall;
   assign if_id_stall  = resetn & ctl.if_id_stall;
   assign id_ex_stall  = resetn & ctl.id_ex_stall;
   assign ex_mem_stall = resetn & ctl.ex_mem_stall;
   assign if_id_flush  = resetn & ctl.if_id_flush;
   assign id_ex_flush  = resetn & ctl.id_ex_flush;
   assign ex_mem_flush = resetn & ctl.ex_mem_flush;
   assign mem_wb_flush = resetn & ctl.mem_wb_flush;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         mstate   <= M_IDLE;
         exc_pend <= 1'b0;
      end else begin
         mstate <= mstate_nxt;
         if (complete) exc_pend <= 1'b0;
         else if (mem_exc & (mstate != M_IDLE)) exc_pend <= 1'b1;
      end
   end

   div_sched #(
      .DIV_CYCLES (DIV_CYCLES)
   ) u_div_sched (
      .clk       (clk),
      .resetn    (resetn),
      .ex_div    (ex_div),
      .adv       (~ex_mem_stall),
      .kill      (exc_take),
      .div_stall (div_stall_int),
      .div_busy  (div_busy_int),
      .div_done  (div_done_int)
   );

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// +-----------------------------------------------------------------+
// | tb_pipe_hazard_ctrl: table, directed and random checks          |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_pipe_hazard_ctrl;

   localparam int DIV_CYCLES = 33;

   typedef struct packed {
      logic [5:0] rs;
      logic [5:0] rt;
      logic       rs_ren;
      logic       rt_ren;
      logic       ex_load;
      logic       ex_regwen;
      logic [5:0] wreg;
      logic       ex_div;
      logic       mem_data_en;
      logic       mem_exc;
      logic       addr_ok;
      logic       data_ok;
      logic       if_wait;
   } in_t;

   typedef struct {
      in_t         stim;
      logic [11:0] exp;
   } vec_t;

   logic       clk;
   logic       resetn;
   logic [5:0] id_rs, id_rt, ex_wreg;
   logic       id_rs_ren, id_rt_ren, ex_load, ex_regwen, ex_div;
   logic       mem_data_en, mem_exc, data_addr_ok, data_data_ok, if_wait;
   logic       data_req, div_busy, div_done, exc_take;
   logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
   logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
   logic [11:0] dut_out;
   logic [11:0] last;

   int checks = 0;
   int errors = 0;

   // Reference state: transaction in flight, address phase done, deferred
   // exception, divide in progress and cycles elapsed since it began.
   logic m_bus  = 1'b0;
   logic m_addr = 1'b0;
   logic m_pend = 1'b0;
   logic m_div  = 1'b0;
   int   m_age  = 0;

   pipe_hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES)) dut (
      .clk(clk), .resetn(resetn),
      .id_rs(id_rs), .id_rt(id_rt), .id_rs_ren(id_rs_ren), .id_rt_ren(id_rt_ren),
      .ex_load(ex_load), .ex_regwen(ex_regwen), .ex_wreg(ex_wreg), .ex_div(ex_div),
      .mem_data_en(mem_data_en), .mem_exc(mem_exc),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .if_wait(if_wait),
      .data_req(data_req), .div_busy(div_busy), .div_done(div_done), .exc_take(exc_take),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
      .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush)
   );

   // Bit order: req, busy, done, take, stalls pc..ex_mem, flushes if_id..mem_wb.
   assign dut_out = {data_req, div_busy, div_done, exc_take,
                     pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                     if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [11:0] model_out(input in_t v);
      logic req_new, finishing, waiting, dstall, lu;
      logic [11:0] r;
      r = '0;
      if (!resetn) return r;
      req_new   = !m_bus && v.mem_data_en && !v.mem_exc;
      finishing = m_bus && m_addr && v.data_ok;
      waiting   = req_new || (m_bus && !finishing);
      dstall    = m_div ? (m_age < DIV_CYCLES) : v.ex_div;
      lu = v.ex_load && v.ex_regwen && (v.wreg != 0) &&
           ((v.rs_ren && v.rs == v.wreg) || (v.rt_ren && v.rt == v.wreg));
      r[11] = req_new || (m_bus && !m_addr);
      r[10] = m_div && (m_age <= DIV_CYCLES);
      r[9]  = m_div && (m_age >= DIV_CYCLES);
      if (v.mem_exc && !m_bus)                    r[8:0] = 9'h10F;
      else if (finishing && (m_pend || v.mem_exc)) r[8:0] = 9'h10E;
      else if (waiting)                           r[7:0] = 8'hF1;
      else if (dstall)                            r[7:0] = 8'hE2;
      else if (lu)                                r[7:0] = 8'hC4;
      else if (v.if_wait)                         r[7:0] = 8'h88;
      return r;
   endfunction

   task automatic model_step(input in_t v);
      logic [11:0] o;
      logic req_new, finishing;
      o = model_out(v);
      if (!resetn) begin
         m_bus = 0; m_addr = 0; m_pend = 0; m_div = 0; m_age = 0;
         return;
      end
      req_new   = !m_bus && v.mem_data_en && !v.mem_exc;
      finishing = m_bus && m_addr && v.data_ok;
      if (finishing) begin
         m_bus = 0; m_pend = 0;
      end else begin
         if (v.mem_exc && m_bus) m_pend = 1;
         if (req_new) begin
            m_bus = 1; m_addr = v.addr_ok;
         end else if (m_bus && v.addr_ok) m_addr = 1;
      end
      if (o[8]) m_div = 0;
      else if (!m_div) begin
         if (v.ex_div) begin m_div = 1; m_age = 1; end
      end else if (m_age >= DIV_CYCLES && !o[4]) m_div = 0;
      else m_age++;
   endtask

   task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %03h expected %03h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic apply(input in_t v);
      id_rs = v.rs; id_rt = v.rt; id_rs_ren = v.rs_ren; id_rt_ren = v.rt_ren;
      ex_load = v.ex_load; ex_regwen = v.ex_regwen; ex_wreg = v.wreg; ex_div = v.ex_div;
      mem_data_en = v.mem_data_en; mem_exc = v.mem_exc;
      data_addr_ok = v.addr_ok; data_data_ok = v.data_ok; if_wait = v.if_wait;
   endtask

   // One clock: drive, compare with the model mid-cycle, advance the model.
   task automatic cyc(input in_t v);
      apply(v);
      @(negedge clk);
      last = dut_out;
      chk("model", last, model_out(v));
      @(posedge clk);
      model_step(v);
      #1;
   endtask

   task automatic step_chk(input string name, input in_t v, input logic [11:0] exp);
      cyc(v);
      chk(name, last, exp);
   endtask

   function automatic in_t mk(input logic [5:0] rs, input logic [5:0] rt,
                              input logic rsr, input logic rtr, input logic ld,
                              input logic rw, input logic [5:0] wr, input logic ifw,
                              input logic exc, input logic den);
      in_t v;
      v = '0;
      v.rs = rs; v.rt = rt; v.rs_ren = rsr; v.rt_ren = rtr; v.ex_load = ld;
      v.ex_regwen = rw; v.wreg = wr; v.if_wait = ifw; v.mem_exc = exc; v.mem_data_en = den;
      return v;
   endfunction

   vec_t tbl[12];
   in_t  z;
   in_t  v;
   logic [11:0] e;

   initial begin
      z = '0;
      tbl[0]  = '{mk(0,0,0,0,0,0,0,0,0,0), 12'h000};
      tbl[1]  = '{mk(5,0,1,0,1,1,5,0,0,0), 12'h0C4};
      tbl[2]  = '{mk(0,5,0,1,1,1,5,0,0,0), 12'h0C4};
      tbl[3]  = '{mk(0,0,1,1,1,1,0,0,0,0), 12'h000};
      tbl[4]  = '{mk(5,0,1,0,1,0,5,0,0,0), 12'h000};
      tbl[5]  = '{mk(5,0,0,0,1,1,5,0,0,0), 12'h000};
      tbl[6]  = '{mk(5,0,1,0,0,1,5,0,0,0), 12'h000};
      tbl[7]  = '{mk(5,6,1,1,1,1,7,0,0,0), 12'h000};
      tbl[8]  = '{mk(0,0,0,0,0,0,0,1,0,0), 12'h088};
      tbl[9]  = '{mk(5,0,1,0,1,1,5,1,0,0), 12'h0C4};
      tbl[10] = '{mk(5,0,1,0,1,1,5,1,1,1), 12'h10F};
      tbl[11] = '{mk(0,0,0,0,0,0,0,1,1,0), 12'h10F};

      resetn = 1'b0;
      apply(z);
      @(posedge clk); #1;
      // Outputs must stay low in reset even with every request input active.
      v = mk(5,0,1,0,1,1,5,1,1,1); v.ex_div = 1; v.addr_ok = 1; v.data_ok = 1;
      step_chk("reset_outputs", v, 12'h000);
      resetn = 1'b1;
      step_chk("after_reset", z, 12'h000);

      for (int i = 0; i < 12; i++)
         step_chk($sformatf("tbl%0d", i), tbl[i].stim, tbl[i].exp);

      step_chk("lu_one", tbl[1].stim, 12'h0C4);
      step_chk("lu_drop", z, 12'h000);

      // Handshake: addr_ok 2 cycles late, data_ok 3 cycles after that.
      for (int k = 0; k <= 6; k++) begin
         v = z;
         v.mem_data_en = (k <= 5);
         v.addr_ok     = (k == 2);
         v.data_ok     = (k == 5);
         e = (k <= 2) ? 12'h8F1 : (k <= 4) ? 12'h0F1 : 12'h000;
         step_chk($sformatf("hs_k%0d", k), v, e);
      end

      // Plain divide.
      for (int k = 0; k <= 34; k++) begin
         v = z;
         v.ex_div = (k <= 33);
         e = (k == 0) ? 12'h0E2 : (k <= 32) ? 12'h4E2 : (k == 33) ? 12'h600 : 12'h000;
         step_chk($sformatf("div_k%0d", k), v, e);
      end

      // Divide overlapped by a data wait spanning its last cycles.
      for (int k = 0; k <= 37; k++) begin
         v = z;
         v.ex_div      = (k <= 36);
         v.mem_data_en = (k >= 30 && k <= 36);
         v.addr_ok     = (k == 30);
         v.data_ok     = (k == 36);
         case (k)
            0:       e = 12'h0E2;
            30:      e = 12'hCF1;
            31, 32:  e = 12'h4F1;
            33:      e = 12'h6F1;
            34, 35:  e = 12'h2F1;
            36:      e = 12'h200;
            37:      e = 12'h000;
            default: e = 12'h4E2;
         endcase
         step_chk($sformatf("divw_k%0d", k), v, e);
      end

      // Exception in idle memory while a divide is running.
      for (int k = 0; k <= 6; k++) begin
         v = z;
         v.ex_div      = (k <= 5);
         v.mem_exc     = (k == 5);
         v.mem_data_en = (k == 5);
         e = (k == 0) ? 12'h0E2 : (k <= 4) ? 12'h4E2 : (k == 5) ? 12'h50F : 12'h000;
         step_chk($sformatf("exc_k%0d", k), v, e);
      end

      // Interrupt arriving while the data phase is outstanding.
      for (int k = 0; k <= 4; k++) begin
         v = z;
         v.mem_data_en = (k <= 3);
         v.addr_ok     = (k == 0);
         v.mem_exc     = (k == 1);
         v.data_ok     = (k == 3);
         e = (k == 0) ? 12'h8F1 : (k <= 2) ? 12'h0F1 : (k == 3) ? 12'h10E : 12'h000;
         step_chk($sformatf("irq_k%0d", k), v, e);
      end

      // Reset in the address phase during a divide.
      v = z; v.ex_div = 1;
      step_chk("rst_k0", v, 12'h0E2);
      v.mem_data_en = 1;
      step_chk("rst_k1", v, 12'hCF1);
      resetn = 1'b0;
      step_chk("rst_k2", v, 12'h000);
      resetn = 1'b1;
      v = z; v.addr_ok = 1; v.data_ok = 1;
      step_chk("rst_k3", v, 12'h000);

      for (int n = 0; n < 4000; n++) begin
         v.rs          = 6'($urandom_range(0, 3));
         v.rt          = 6'($urandom_range(0, 3));
         v.wreg        = 6'($urandom_range(0, 3));
         v.rs_ren      = 1'($urandom_range(0, 1));
         v.rt_ren      = 1'($urandom_range(0, 1));
         v.ex_load     = 1'($urandom_range(0, 1));
         v.ex_regwen   = 1'($urandom_range(0, 1));
         v.ex_div      = ($urandom_range(0, 30) == 0);
         v.mem_data_en = ($urandom_range(0, 3) == 0);
         v.mem_exc     = ($urandom_range(0, 40) == 0);
         v.addr_ok     = 1'($urandom_range(0, 1));
         v.data_ok     = ($urandom_range(0, 2) == 0);
         v.if_wait     = ($urandom_range(0, 4) == 0);
         resetn        = ($urandom_range(0, 300) != 0);
         cyc(v);
      end
      resetn = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
